// File: rtl/bf_acc_norm_ctrl.sv
// Bilateral-filter window sequencer: registers the two external summers over N_PASS beats,
// then normalises weighted-intensity / weight with a restoring divider, one quotient bit per cycle.
module bf_acc_norm_ctrl #(
  parameter int N_PASS = 4,
  parameter int W_W    = 20,
  parameter int W_WI   = 28,
  parameter int W_PIX  = 8,
  localparam int PW    = (N_PASS > 1) ? $clog2(N_PASS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_W-1:0]   sum_w_in,
  input  logic [W_WI-1:0]  sum_wi_in,
  output logic [W_W-1:0]   reg_w,
  output logic [W_WI-1:0]  reg_wi,
  output logic             en_sum,
  output logic [PW-1:0]    pass_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_PIX-1:0] out_pix
);

  localparam int CW = (W_PIX > 1) ? $clog2(W_PIX) : 1;
  localparam int WC = W_WI + W_PIX;

  typedef enum logic [1:0] {ACC, DIV, OUT} state_t;

  state_t           state;
  logic [W_WI-1:0]  rem;
  logic [W_W-1:0]   divisor;
  logic [W_PIX-1:0] q;
  logic [CW-1:0]    cnt;
  logic             zero_div;
  logic             sat;

  logic [WC-1:0]    sh_div;
  logic             take;
  logic [W_WI-1:0]  rem_nxt;
  logic [W_PIX-1:0] q_nxt;
  logic             entry_zero;
  logic             entry_sat;

  // NOTE: every signal driven here gets a value on every path first; a missing default infers a latch.
  always_comb begin
    in_ready   = (state == ACC);
    en_sum     = in_valid & in_ready;
    // Compare in WC bits so divisor << cnt can never overflow.
    sh_div     = WC'(divisor) << cnt;
    take       = WC'(rem) >= sh_div;
    rem_nxt    = take ? W_WI'(WC'(rem) - sh_div) : rem;
    q_nxt      = take ? (q | (W_PIX'(1) << cnt)) : q;
    entry_zero = (sum_w_in == '0);
    entry_sat  = WC'(sum_wi_in) >= (WC'(sum_w_in) << W_PIX);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACC;
      reg_w     <= '0;
      reg_wi    <= '0;
      pass_idx  <= '0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      rem       <= '0;
      divisor   <= '0;
      q         <= '0;
      cnt       <= '0;
      zero_div  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (en_sum) begin
            reg_w  <= sum_w_in;
            reg_wi <= sum_wi_in;
            if (pass_idx == PW'(N_PASS - 1)) begin
              pass_idx <= '0;
              state    <= DIV;
              rem      <= sum_wi_in;
              divisor  <= sum_w_in;
              q        <= '0;
              cnt      <= CW'(W_PIX - 1);
              zero_div <= entry_zero;
              sat      <= entry_sat;
            end else begin
              pass_idx <= pass_idx + 1'b1;
            end
          end
        end
        DIV: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          if (cnt == '0) begin
            state     <= OUT;
            out_valid <= 1'b1;
            // Overrides were resolved at entry; the bit loop still runs so latency is fixed.
            if (zero_div)  out_pix <= '0;
            else if (sat)  out_pix <= '1;
            else           out_pix <= q_nxt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            reg_w     <= '0;
            reg_wi    <= '0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_acc_norm_ctrl.sv
// Self-checking bench for bf_acc_norm_ctrl: models the external summers and checks each pixel
// against an arithmetic reference (floor divide, zero-weight and saturation rules).
module tb_bf_acc_norm_ctrl;

  localparam int N_PASS = 4;
  localparam int W_W    = 20;
  localparam int W_WI   = 28;
  localparam int W_PIX  = 8;
  localparam int PW     = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [W_W-1:0]   sum_w_in;
  logic [W_WI-1:0]  sum_wi_in;
  logic [W_W-1:0]   reg_w;
  logic [W_WI-1:0]  reg_wi;
  logic             en_sum;
  logic [PW-1:0]    pass_idx;
  logic             out_valid;
  logic             out_ready;
  logic [W_PIX-1:0] out_pix;

  logic [W_W-1:0]   part_w;
  logic [W_WI-1:0]  part_wi;

  int vectors = 0;
  int miscompares = 0;
  int en_cnt = 0;

  logic [W_W-1:0]  pw  [N_PASS];
  logic [W_WI-1:0] pwi [N_PASS];
  int              gap [N_PASS];
  int              bp_n;

  bf_acc_norm_ctrl #(.N_PASS(N_PASS), .W_W(W_W), .W_WI(W_WI), .W_PIX(W_PIX)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sum_w_in(sum_w_in), .sum_wi_in(sum_wi_in), .reg_w(reg_w), .reg_wi(reg_wi),
    .en_sum(en_sum), .pass_idx(pass_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix)
  );

  always #5 clk = ~clk;

  // External summers: out_sum = reg_sum + partial, wrapping at the register width.
  assign sum_w_in  = reg_w + part_w;
  assign sum_wi_in = reg_wi + part_wi;

  always @(negedge clk) if (en_sum === 1'b1) en_cnt <= en_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_pix(input longint w, input longint wi);
    longint q;
    if (w == 0) return 0;
    q = wi / w;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic run_pixel();
    longint tw = 0, twi = 0, exp_pix;
    logic [W_W-1:0]  tw_m;
    logic [W_WI-1:0] twi_m;
    int en0 = en_cnt;
    int lat;
    for (int k = 0; k < N_PASS; k++) begin
      in_valid = 1'b0;
      repeat (gap[k]) tick();
      in_valid = 1'b1;
      part_w   = pw[k];
      part_wi  = pwi[k];
      check("pass_idx", 64'(pass_idx), 64'(k));
      check("in_ready_acc", 64'(in_ready), 64'd1);
      tw  += longint'(pw[k]);
      twi += longint'(pwi[k]);
      tick();
    end
    tw_m    = W_W'(tw);
    twi_m   = W_WI'(twi);
    exp_pix = ref_pix(longint'(tw_m), longint'(twi_m));
    // in_valid stays high through DIV/OUT with a nonzero partial: it must be ignored.
    part_w  = 20'd7;
    part_wi = 28'd9;
    check("reg_w_total", 64'(reg_w), 64'(tw_m));
    check("reg_wi_total", 64'(reg_wi), 64'(twi_m));
    check("pass_idx_wrap", 64'(pass_idx), 64'd0);
    check("in_ready_div", 64'(in_ready), 64'd0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd9);
    check("out_pix", 64'(out_pix), 64'(exp_pix));
    repeat (bp_n) begin
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_pix", 64'(out_pix), 64'(exp_pix));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_en_sum", 64'(en_sum), 64'd0);
      check("bp_reg_w", 64'(reg_w), 64'(tw_m));
      check("bp_reg_wi", 64'(reg_wi), 64'(twi_m));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_reg_w", 64'(reg_w), 64'd0);
    check("post_reg_wi", 64'(reg_wi), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check("en_sum_count", 64'(en_cnt - en0), 64'(N_PASS));
  endtask

  task automatic pix(input int a0, a1, a2, a3, input int b0, b1, b2, b3);
    pw[0] = W_W'(a0);   pw[1] = W_W'(a1);   pw[2] = W_W'(a2);   pw[3] = W_W'(a3);
    pwi[0] = W_WI'(b0); pwi[1] = W_WI'(b1); pwi[2] = W_WI'(b2); pwi[3] = W_WI'(b3);
    run_pixel();
  endtask

  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      part_w   = 20'd1000;
      part_wi  = 28'd99999;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic reset_and_watch(input string tag);
    logic seen = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check({tag, "_reg_w"}, 64'(reg_w), 64'd0);
    check({tag, "_reg_wi"}, 64'(reg_wi), 64'd0);
    check({tag, "_pass_idx"}, 64'(pass_idx), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    repeat (12) begin
      seen |= out_valid;
      tick();
    end
    check({tag, "_no_out_valid"}, 64'(seen), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    part_w    = '0;
    part_wi   = '0;
    bp_n      = 0;
    for (int k = 0; k < N_PASS; k++) gap[k] = 0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_reg_w", 64'(reg_w), 64'd0);
    check("rst_reg_wi", 64'(reg_wi), 64'd0);
    check("rst_pass_idx", 64'(pass_idx), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pix", 64'(out_pix), 64'd0);
    check("rst_en_sum", 64'(en_sum), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    pix(100, 100, 100, 100, 5000, 5000, 5000, 5000);
    pix(1, 1, 1, 0, 3, 3, 3, 1);
    pix(0, 0, 0, 0, 20, 20, 20, 17);
    pix(1, 0, 0, 0, 100, 100, 100, 0);
    pix(1, 1, 0, 0, 200, 200, 100, 11);
    pix(1, 1, 0, 0, 200, 200, 100, 10);

    bp_n = 5;
    pix(100, 100, 100, 100, 5000, 5000, 5000, 5000);
    bp_n = 0;

    // Gapped input: in_valid pattern 1,0,0,1,1,0,1.
    gap[1] = 2; gap[3] = 1;
    pix(100, 100, 100, 100, 5000, 5000, 5000, 5000);
    gap[1] = 0; gap[3] = 0;

    feed(2);
    reset_and_watch("rst_acc");
    pix(10, 20, 30, 40, 1000, 2000, 3000, 4000);

    feed(4);
    tick(); tick(); tick();
    reset_and_watch("rst_div");
    pix(5, 5, 5, 5, 600, 600, 600, 600);

    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < N_PASS; k++) begin
        gap[k] = int'($urandom_range(0, 2));
        if (n < 2) begin
          pw[k]  = W_W'($urandom);
          pwi[k] = W_WI'($urandom);
        end else begin
          pw[k]  = W_W'($urandom_range(0, 3000));
          pwi[k] = W_WI'(int'(pw[k]) * int'($urandom_range(0, 300)) + int'($urandom_range(0, 500)));
        end
      end
      bp_n = int'($urandom_range(0, 3));
      run_pixel();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
